// File: rtl/im_loader_pkg.sv
// Shared types for the instruction-memory boot loader.
package im_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int LOADER_HDR_BYTES  = 2;
    localparam int LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
module im_loader_byte_packer
    import im_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_LANE = 2'(LOADER_WORD_BYTES - 1);

    logic [1:0]  lane_q;
    logic [23:0] low_q;
    logic [31:0] word_q;
    logic        valid_q;

    // word_q only changes on completion, so it holds between strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q  <= 2'd0;
            low_q   <= 24'd0;
            word_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (byte_valid_i) begin
                lane_q <= lane_q + 2'd1;
                if (lane_q == LAST_LANE) begin
                    word_q  <= {byte_i, low_q};
                    valid_q <= 1'b1;
                end else begin
                    unique case (lane_q)
                        2'd0:    low_q[7:0]   <= byte_i;
                        2'd1:    low_q[15:8]  <= byte_i;
                        default: low_q[23:16] <= byte_i;
                    endcase
                end
            end
        end
    end

    assign lane_o       = lane_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/im_loader.sv
// Boot loader: framed byte stream -> IM write port, holds core in reset
// until the whole image is stored and its XOR checksum matches.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int IM_DEPTH = 256,
    parameter int ADDR_W   = $clog2(IM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    localparam logic [1:0]  LAST_LANE = 2'(LOADER_WORD_BYTES - 1);
    localparam logic [16:0] DEPTH_N   = 17'(IM_DEPTH);

    loader_state_t     state_q;
    logic [15:0]       n_q;
    logic [7:0]        cksum_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [15:0]       words_q;
    logic              core_reset_q;
    logic              done_q;
    logic              err_q;

    logic        accept;
    logic        pay_acc;
    logic        word_end;
    logic [1:0]  lane;
    logic [15:0] n_d;
    logic [7:0]  cksum_d;

    assign rx_ready = (state_q != DONE) && (state_q != ERROR);
    assign accept   = rx_valid && rx_ready;
    assign pay_acc  = accept && (state_q == PAYLOAD);
    assign word_end = pay_acc && (lane == LAST_LANE);
    assign n_d      = {rx_data, n_q[7:0]};
    assign cksum_d  = cksum_q ^ rx_data;

    im_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (pay_acc),
        .byte_i       (rx_data),
        .lane_o       (lane),
        .word_valid_o (im_we),
        .word_o       (im_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HDR_LO;
            n_q          <= 16'd0;
            cksum_q      <= 8'd0;
            waddr_q      <= '0;
            words_q      <= 16'd0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // address and count move on the edge that raises im_we
            if (word_end) begin
                waddr_q <= words_q[ADDR_W-1:0];
                words_q <= words_q + 16'd1;
            end
            if (pay_acc) cksum_q <= cksum_d;
            if (accept) begin
                unique case (state_q)
                    HDR_LO: begin
                        n_q[7:0] <= rx_data;
                        state_q  <= HDR_HI;
                    end
                    HDR_HI: begin
                        n_q <= n_d;
                        if ({1'b0, n_d} > DEPTH_N) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else if (n_d == 16'd0) begin
                            state_q <= CHECK;
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (word_end && (words_q + 16'd1 == n_q))
                            state_q <= CHECK;
                    end
                    CHECK: begin
                        if (rx_data == cksum_q) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_waddr     = waddr_q;
    assign core_reset   = core_reset_q;
    assign load_done    = done_q;
    assign load_error   = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: frame table plus hand-written corner sequences.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        im_we;
    logic [7:0]  im_waddr;
    logic [31:0] im_wdata;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    im_loader #(.IM_DEPTH(256)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        int              len;
        logic [0:15][7:0] b;
        bit              gaps;
        bit              done;
        bit              err;
        int              nw;
        logic [7:0]      fa;
        logic [31:0]     fd;
        logic [7:0]      la;
        logic [31:0]     ld;
        logic [15:0]     words;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    string cur = "init";

    int          cyc = 0;
    int          nwr = 0;
    int          last_we = -1;
    int          cr_fall = -1;
    int          we_err = 0;
    logic [7:0]  mfa, mla;
    logic [31:0] mfd, mld;

    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            if (nwr == 0) begin
                mfa = im_waddr;
                mfd = im_wdata;
            end
            mla = im_waddr;
            mld = im_wdata;
            nwr++;
            last_we = cyc;
            if (load_error) we_err++;
        end
        if (!core_reset && cr_fall < 0) cr_fall = cyc;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s/%0s: got %0h expected %0h", cur, nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_flags",
            32'({rx_ready, im_we, core_reset, load_done, load_error}),
            32'h14);
        chk("rst_addr", 32'(im_waddr), 32'h0);
        chk("rst_data", im_wdata, 32'h0);
        chk("rst_words", 32'(words_loaded), 32'h0);
        nwr = 0;
        last_we = -1;
        cr_fall = -1;
        we_err = 0;
        reset = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk);
        if (!rx_ready) chk("ready_before_byte", 32'(rx_ready), 32'h1);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
    endtask

    task automatic idle_settle();
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t  vt[6];
    string names[6];

    initial begin
        int n0;
        logic [7:0] ck;

        names[0] = "one_word";
        vt[0] = '{7, {8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h46, 72'h0},
                  1'b0, 1'b1, 1'b0, 1,
                  8'h00, 32'h00500513, 8'h00, 32'h00500513, 16'd1};
        names[1] = "two_gaps";
        vt[1] = '{11, {8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                       8'h13, 8'h81, 8'h20, 8'h00, 8'h31, 40'h0},
                  1'b1, 1'b1, 1'b0, 2,
                  8'h00, 32'h00100093, 8'h01, 32'h00208113, 16'd2};
        names[2] = "bad_cksum";
        vt[2] = '{7, {8'h01, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h44, 72'h0},
                  1'b0, 1'b0, 1'b1, 1,
                  8'h00, 32'h00500513, 8'h00, 32'h00500513, 16'd1};
        names[3] = "too_big";
        vt[3] = '{2, {8'h01, 8'h01, 112'h0},
                  1'b0, 1'b0, 1'b1, 0,
                  8'h00, 32'h0, 8'h00, 32'h0, 16'd0};
        names[4] = "zero_ok";
        vt[4] = '{3, {8'h00, 8'h00, 8'h00, 104'h0},
                  1'b0, 1'b1, 1'b0, 0,
                  8'h00, 32'h0, 8'h00, 32'h0, 16'd0};
        names[5] = "zero_bad";
        vt[5] = '{3, {8'h00, 8'h00, 8'h01, 104'h0},
                  1'b0, 1'b0, 1'b1, 0,
                  8'h00, 32'h0, 8'h00, 32'h0, 16'd0};

        for (int i = 0; i < 6; i++) begin
            cur = names[i];
            do_reset();
            for (int j = 0; j < vt[i].len; j++)
                send(vt[i].b[j], vt[i].gaps ? int'($urandom_range(0, 2)) : 0);
            idle_settle();
            chk("done", 32'(load_done), 32'(vt[i].done));
            chk("error", 32'(load_error), 32'(vt[i].err));
            chk("core_reset", 32'(core_reset), 32'(!vt[i].done));
            chk("rx_ready", 32'(rx_ready), 32'h0);
            chk("nwrites", nwr, vt[i].nw);
            chk("words", 32'(words_loaded), 32'(vt[i].words));
            if (vt[i].nw > 0) begin
                chk("first_addr", 32'(mfa), 32'(vt[i].fa));
                chk("first_data", mfd, vt[i].fd);
                chk("last_addr", 32'(mla), 32'(vt[i].la));
                chk("last_data", mld, vt[i].ld);
            end
            if (vt[i].done)
                chk("we_before_run", 32'(cr_fall > last_we), 32'h1);
            if (vt[i].err)
                chk("we_after_err", we_err, 0);
            n0 = nwr;
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data = 8'h55;
            repeat (3) @(negedge clk);
            chk("stall_ready", 32'(rx_ready), 32'h0);
            rx_valid = 1'b0;
            chk("stall_nwr", nwr, n0);
            chk("stall_words", 32'(words_loaded), 32'(vt[i].words));
        end

        cur = "full_depth";
        do_reset();
        send(8'h00, 0);
        send(8'h01, 0);
        ck = 8'h00;
        for (int k = 0; k < 1024; k++) begin
            ck = ck ^ 8'(k);
            send(8'(k), 0);
        end
        send(ck, 0);
        idle_settle();
        chk("done", 32'(load_done), 32'h1);
        chk("core_reset", 32'(core_reset), 32'h0);
        chk("nwrites", nwr, 256);
        chk("last_addr", 32'(mla), 32'hFF);
        chk("last_data", mld, 32'hFFFEFDFC);
        chk("words", 32'(words_loaded), 32'd256);

        cur = "mid_reset";
        do_reset();
        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h05, 0);
        send(8'h50, 0);
        send(8'h00, 0);
        send(8'hAA, 0);
        send(8'hBB, 0);
        chk("pre_nwrites", nwr, 1);
        chk("pre_words", 32'(words_loaded), 32'd1);
        chk("pre_core_reset", 32'(core_reset), 32'h1);
        do_reset();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h05, 0);
        send(8'h50, 0);
        send(8'h00, 0);
        send(8'h46, 0);
        idle_settle();
        chk("done", 32'(load_done), 32'h1);
        chk("error", 32'(load_error), 32'h0);
        chk("nwrites", nwr, 1);
        chk("addr", 32'(mfa), 32'h0);
        chk("data", mfd, 32'h00500513);
        chk("words", 32'(words_loaded), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
